// File: rtl/chi5_link_ctrl.sv
// CHI link-layer controller: independent TX/RX four-state link FSMs with
// per-channel L-credit accounting for NUM_CH flit channels.
module chi5_link_ctrl #(
  parameter  int NUM_CH  = 4,
  parameter  int MAX_CRD = 15,
  localparam int CW      = $clog2(MAX_CRD + 1)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              lnk_up_req,
  output logic              txlinkactivereq,
  input  logic              txlinkactiveack,
  input  logic              rxlinkactivereq,
  output logic              rxlinkactiveack,
  input  logic [NUM_CH-1:0] tx_lcrdv,
  input  logic [NUM_CH-1:0] tx_flit_req,
  output logic [NUM_CH-1:0] tx_flitv,
  output logic [NUM_CH-1:0] tx_lcrd_rtn,
  output logic [NUM_CH-1:0] rx_lcrdv,
  input  logic [NUM_CH-1:0] rx_flitv,
  input  logic [NUM_CH-1:0] rx_lcrd_rtn,
  output logic [1:0]        tx_state,
  output logic [1:0]        rx_state,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_ACT   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DEACT = 2'd3
  } link_state_e;

  localparam logic [CW-1:0] MAX_V  = CW'(MAX_CRD);
  localparam logic [CW-1:0] ONE_V  = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_V = CW'(1'b0);

  link_state_e       tx_state_r, rx_state_r;
  logic              tx_req_r, rx_ack_r, err_r;
  logic [NUM_CH-1:0] rx_lcrdv_r;
  logic [CW-1:0]     tx_cnt_r     [NUM_CH];
  logic [CW-1:0]     rx_out_r     [NUM_CH];
  logic [CW-1:0]     tx_cnt_nxt_s [NUM_CH];
  logic [CW-1:0]     rx_out_nxt_s [NUM_CH];
  logic [NUM_CH-1:0] tx_flitv_s, tx_rtn_s, tx_nz_s, rx_nz_s, rx_dec_s;
  logic              tx_err_s, rx_err_s, rx_run_nxt_s;

  // Credit arithmetic, issue gating and error detection for both directions
  always_comb begin
    tx_err_s     = 1'b0;
    rx_err_s     = 1'b0;
    tx_flitv_s   = '0;
    tx_rtn_s     = '0;
    tx_nz_s      = '0;
    rx_nz_s      = '0;
    rx_dec_s     = '0;
    rx_run_nxt_s = rxlinkactivereq &&
                   ((rx_state_r == ST_RUN) || (rx_state_r == ST_ACT && lnk_up_req));
    for (int c = 0; c < NUM_CH; c++) begin
      tx_nz_s[c]    = (tx_cnt_r[c] != ZERO_V);
      tx_flitv_s[c] = tx_flit_req[c] && (tx_state_r == ST_RUN) && tx_nz_s[c];
      tx_rtn_s[c]   = (tx_state_r == ST_DEACT) && tx_nz_s[c];
      tx_cnt_nxt_s[c] = tx_cnt_r[c];
      if (tx_lcrdv[c] && (tx_state_r == ST_STOP)) begin
        tx_err_s = 1'b1;
      end else if (tx_lcrdv[c]) begin
        if (tx_flitv_s[c] || tx_rtn_s[c]) begin
          tx_cnt_nxt_s[c] = tx_cnt_r[c];
        end else if (tx_cnt_r[c] == MAX_V) begin
          tx_err_s = 1'b1;
        end else begin
          tx_cnt_nxt_s[c] = tx_cnt_r[c] + ONE_V;
        end
      end else if (tx_flitv_s[c] || tx_rtn_s[c]) begin
        tx_cnt_nxt_s[c] = tx_cnt_r[c] - ONE_V;
      end else begin
        tx_cnt_nxt_s[c] = tx_cnt_r[c];
      end

      // An illegal consume is flagged and not applied, so the counter never wraps
      rx_nz_s[c]      = (rx_out_r[c] != ZERO_V);
      rx_dec_s[c]     = rx_flitv[c] || rx_lcrd_rtn[c];
      rx_out_nxt_s[c] = rx_out_r[c];
      if ((rx_flitv[c] && rx_lcrd_rtn[c]) || (rx_dec_s[c] && !rx_nz_s[c])) begin
        rx_err_s        = 1'b1;
        rx_out_nxt_s[c] = rx_lcrdv_r[c] ? (rx_out_r[c] + ONE_V) : rx_out_r[c];
      end else if (rx_lcrdv_r[c] && !rx_dec_s[c]) begin
        rx_out_nxt_s[c] = rx_out_r[c] + ONE_V;
      end else if (!rx_lcrdv_r[c] && rx_dec_s[c]) begin
        rx_out_nxt_s[c] = rx_out_r[c] - ONE_V;
      end else begin
        rx_out_nxt_s[c] = rx_out_r[c];
      end
    end
  end

  // TX link FSM with registered activation request
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tx_state_r <= ST_STOP;
      tx_req_r   <= 1'b0;
    end else begin
      case (tx_state_r)
        ST_STOP: if (lnk_up_req && !txlinkactiveack) begin
          tx_state_r <= ST_ACT;
          tx_req_r   <= 1'b1;
        end
        ST_ACT: if (txlinkactiveack) tx_state_r <= ST_RUN;
        ST_RUN: if (!lnk_up_req) begin
          tx_state_r <= ST_DEACT;
          tx_req_r   <= 1'b0;
        end
        ST_DEACT: if (!txlinkactiveack && (tx_nz_s == '0)) tx_state_r <= ST_STOP;
        default: begin
          tx_state_r <= ST_STOP;
          tx_req_r   <= 1'b0;
        end
      endcase
    end
  end

  // RX link FSM with registered activation acknowledge
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rx_state_r <= ST_STOP;
      rx_ack_r   <= 1'b0;
    end else begin
      case (rx_state_r)
        ST_STOP: if (rxlinkactivereq) rx_state_r <= ST_ACT;
        ST_ACT: begin
          if (!rxlinkactivereq) begin
            rx_state_r <= ST_STOP;
          end else if (lnk_up_req) begin
            rx_state_r <= ST_RUN;
            rx_ack_r   <= 1'b1;
          end
        end
        ST_RUN: if (!rxlinkactivereq) rx_state_r <= ST_DEACT;
        ST_DEACT: if (rx_nz_s == '0) begin
          rx_state_r <= ST_STOP;
          rx_ack_r   <= 1'b0;
        end
        default: begin
          rx_state_r <= ST_STOP;
          rx_ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Credit counters, registered grants (look ahead one cycle) and sticky error
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tx_cnt_r[c] <= ZERO_V;
        rx_out_r[c] <= ZERO_V;
      end
      rx_lcrdv_r <= '0;
      err_r      <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        tx_cnt_r[c]   <= tx_cnt_nxt_s[c];
        rx_out_r[c]   <= rx_out_nxt_s[c];
        rx_lcrdv_r[c] <= rx_run_nxt_s && (rx_out_nxt_s[c] < MAX_V);
      end
      err_r <= err_r | tx_err_s | rx_err_s;
    end
  end

  assign txlinkactivereq = tx_req_r;
  assign rxlinkactiveack = rx_ack_r;
  assign tx_flitv        = tx_flitv_s;
  assign tx_lcrd_rtn     = tx_rtn_s;
  assign rx_lcrdv        = rx_lcrdv_r;
  assign tx_state        = tx_state_r;
  assign rx_state        = rx_state_r;
  assign err             = err_r;

endmodule

// File: doc/chi5_link_ctrl.md
Name: chi5_link_ctrl

Overview:
Parametrised CHI link-layer controller that pairs a full four-state TX link FSM and RX link FSM with per-channel L-credit accounting. It covers NUM_CH flit channels (REQ/RSP/SNP/DAT style).
- The TX side gates local flit issue on received credits and returns all held credits during deactivation.
- The RX side grants credits to the remote transmitter and recovers them before stopping.
- It sits between the protocol layer and the physical CHI link pins.

Parameters:
NUM_CH, 4, number of independent flit channels.
MAX_CRD, 15, maximum L-credits per channel per direction (1..15); counter width CW = $clog2(MAX_CRD+1).

Ports:
ACLK  in  1  clock; all logic on posedge.
ARESET  in  1  reset; synchronous, active-high.
lnk_up_req  in  1  local request for the link to be up (level).
txlinkactivereq  out  1  TX link activation request to remote.
txlinkactiveack  in  1  remote RX acknowledge.
rxlinkactivereq  in  1  remote TX activation request.
rxlinkactiveack  out  1  local RX acknowledge.
tx_lcrdv  in  NUM_CH  one credit received per set bit per cycle.
tx_flit_req  in  NUM_CH  protocol layer wants to send a flit on channel c.
tx_flitv  out  NUM_CH  flit sent on channel c this cycle.
tx_lcrd_rtn  out  NUM_CH  credit-return link flit sent on channel c.
rx_lcrdv  out  NUM_CH  one credit granted to remote on channel c.
rx_flitv  in  NUM_CH  protocol flit received on channel c; consumes a credit.
rx_lcrd_rtn  in  NUM_CH  credit-return link flit received on channel c.
tx_state  out  2  0 STOP, 1 ACT, 2 RUN, 3 DEACT.
rx_state  out  2  same encoding.
err  out  1  sticky protocol error.

Behaviour:
Reset:
- Both FSMs go to STOP.
- All credit counters = 0.
- All outputs = 0.
- ARESET mid-operation aborts immediately, with no credit return.

TX FSM (txlinkactivereq registered, = 1 in ACT and RUN):
- STOP: if lnk_up_req && !txlinkactiveack -> ACT. If the ack is still high, wait.
- ACT: on txlinkactiveack -> RUN.
- RUN: if !lnk_up_req -> DEACT.
- DEACT: every cycle, for each channel with tx_cnt[c] != 0, assert tx_lcrd_rtn[c] and decrement. When txlinkactiveack == 0 and all tx_cnt == 0 -> STOP.

TX credits:
- tx_flitv[c] = tx_flit_req[c] && tx_state == RUN && tx_cnt[c] != 0 (combinational).
- Per cycle: tx_cnt[c] += tx_lcrdv[c], then -= (tx_flitv[c] | tx_lcrd_rtn[c]).
- A credit arriving and a flit or return in the same cycle leaves the count unchanged.
- tx_lcrdv accepted in ACT, RUN and DEACT. In STOP it is ignored and sets err.
- Increment at MAX_CRD saturates and sets err.

RX FSM:
- STOP (ack = 0): on rxlinkactivereq -> ACT.
- ACT (ack = 0): if lnk_up_req -> RUN. If rxlinkactivereq drops first -> STOP.
- RUN (ack = 1): if !rxlinkactivereq -> DEACT.
- DEACT (ack = 1): no new grants. When all rx_out == 0 -> STOP, with ack = 0 the following cycle.

rxlinkactiveack is registered and equals (rx_state ∈ {RUN, DEACT}).

RX credits:
- rx_out[c] counts outstanding granted credits.
- In RUN: rx_lcrdv[c] = (rx_out[c] < MAX_CRD), registered, at most one per cycle per channel.
- Per cycle: rx_out[c] += rx_lcrdv[c], then -= (rx_flitv[c] | rx_lcrd_rtn[c]).
- rx_flitv and rx_lcrd_rtn both set in the same cycle, or either arriving when rx_out[c] == 0, is an error: err is set and the counter holds at 0.
- rx_flitv in DEACT is legal.

General:
- The TX and RX FSMs are independent. Either may be in any state relative to the other.
- err clears only on ARESET.

Test Plan:
1. Reset, lnk_up_req = 1, remote raises txlinkactiveack 2 cycles after txlinkactivereq -> tx_state 0→1→2, txlinkactivereq = 1 from the cycle after lnk_up_req, no tx_flitv before credits.
2. MAX_CRD = 15: 3 tx_lcrdv pulses on ch0, tx_flit_req[0] held -> exactly 3 tx_flitv[0]. Simultaneous credit + flit leaves tx_cnt[0] unchanged. err = 0.
3. From RUN with tx_cnt = {2,0,1,0}, drop lnk_up_req, hold ack 5 cycles -> 2 returns on ch0, 1 on ch2, then STOP once ack = 0.
4. rxlinkactivereq = 1 with lnk_up_req = 1 -> rx ACT→RUN, ack = 1, rx_lcrdv on every channel for 15 consecutive cycles then stops. One rx_flitv[1] -> exactly one re-grant on ch1.
5. In RX RUN, drop rxlinkactivereq, return all 15 credits per channel via rx_lcrd_rtn -> ack stays 1 until the last return, then rx STOP and ack = 0.
6. Error checks: tx_lcrdv in STOP sets err. A 16th credit with MAX_CRD = 15 sets err. ARESET in RUN -> all counters 0, both states STOP, err = 0 the next cycle.
